// File: rtl/mux_pkg.sv
// Shared select encoding for the 4:1 selector family.
package mux_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_I0 = 2'b00;
   localparam sel_t SEL_I1 = 2'b01;
   localparam sel_t SEL_I2 = 2'b10;
   localparam sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_4to1_comb.sv
// Purely combinational 4:1 lane selector. A non-binary select falls back to
// lane i0 so simulation never propagates X through the default branch.
module mux_4to1_comb
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [1:0]       s,
   output logic [WIDTH-1:0] y
);

   // Route the lane named by the select; i0 is both the default and the X fallback.
   always_comb begin
      y = i0;
      case (s)
         SEL_I0:  y = i0;
         SEL_I1:  y = i1;
         SEL_I2:  y = i2;
         SEL_I3:  y = i3;
         default: y = i0;
      endcase
   end

endmodule

// File: rtl/mux_4to1.sv
// 4:1 selector with an immediate output and a one-cycle registered,
// valid-qualified copy for downstream logic that wants a clean flop output.
module mux_4to1
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [1:0]       s,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             out_valid
);

   sel_t sel;

   assign sel = s;

   mux_4to1_comb #(
      .WIDTH(WIDTH)
   ) u_comb (
      .i0(i0),
      .i1(i1),
      .i2(i2),
      .i3(i3),
      .s (sel),
      .y (y)
   );

   // Capture the selected lane on valid beats; the data register holds when idle
   // while the valid flag only reflects the most recent edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y_q <= y;
         end
      end
   end

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 at WIDTH=1 and WIDTH=8 against a lane-array
// reference model.
module tb_mux_4to1;

   typedef struct {
      logic [7:0] l0;
      logic [7:0] l1;
      logic [7:0] l2;
      logic [7:0] l3;
      logic [1:0] sel;
      logic [7:0] exp8;
      logic       exp1;
   } vector_t;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [0:0] a_i0, a_i1, a_i2, a_i3;
   logic [1:0] a_s;
   logic       a_in_valid;
   logic [0:0] a_y, a_y_q;
   logic       a_out_valid;

   logic [7:0] b_i0, b_i1, b_i2, b_i3;
   logic [1:0] b_s;
   logic       b_in_valid;
   logic [7:0] b_y, b_y_q;
   logic       b_out_valid;

   logic [7:0] m_yq;
   logic       m_ov;
   logic [0:0] m1_yq;
   logic       m1_ov;

   int checks = 0;
   int errors = 0;

   vector_t vecs[8];

   mux_4to1 #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .i0(a_i0), .i1(a_i1), .i2(a_i2), .i3(a_i3),
      .s(a_s), .in_valid(a_in_valid),
      .y(a_y), .y_q(a_y_q), .out_valid(a_out_valid)
   );

   mux_4to1 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .i0(b_i0), .i1(b_i1), .i2(b_i2), .i3(b_i3),
      .s(b_s), .in_valid(b_in_valid),
      .y(b_y), .y_q(b_y_q), .out_valid(b_out_valid)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Reference selection: index a lane array; unknown select falls back to lane 0.
   function automatic logic [7:0] refSel(input logic [7:0] l0, input logic [7:0] l1,
                                         input logic [7:0] l2, input logic [7:0] l3,
                                         input logic [1:0] sel);
      logic [7:0] lanes[4];
      lanes = '{l0, l1, l2, l3};
      if ($isunknown(sel)) return l0;
      return lanes[sel];
   endfunction

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                                input logic [7:0] l3, input logic [1:0] sel, input logic valid);
      b_i0 = l0; b_i1 = l1; b_i2 = l2; b_i3 = l3; b_s = sel; b_in_valid = valid;
      a_i0 = l0[0]; a_i1 = l1[0]; a_i2 = l2[0]; a_i3 = l3[0]; a_s = sel; a_in_valid = valid;
   endtask

   // Predict the register state from the pre-edge inputs, then advance one edge.
   task automatic tick();
      logic [7:0] ny;
      logic       nv;
      logic [0:0] ny1;
      logic       nv1;
      if (!rst_n) begin
         ny = '0; nv = 1'b0; ny1 = '0; nv1 = 1'b0;
      end else begin
         nv  = b_in_valid;
         ny  = b_in_valid ? refSel(b_i0, b_i1, b_i2, b_i3, b_s) : m_yq;
         nv1 = a_in_valid;
         ny1 = a_in_valid ? refSel({7'b0, a_i0}, {7'b0, a_i1}, {7'b0, a_i2}, {7'b0, a_i3}, a_s)
                          : {7'b0, m1_yq};
      end
      @(posedge clk);
      #1;
      m_yq = ny; m_ov = nv; m1_yq = ny1; m1_ov = nv1;
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, "_y_q8"}, b_y_q, m_yq);
      checkOutput({tag, "_ov8"}, {7'b0, b_out_valid}, {7'b0, m_ov});
      checkOutput({tag, "_y_q1"}, {7'b0, a_y_q}, {7'b0, m1_yq});
      checkOutput({tag, "_ov1"}, {7'b0, a_out_valid}, {7'b0, m1_ov});
   endtask

   initial begin
      logic [7:0] cyc[4];
      m_yq = '0; m_ov = 1'b0; m1_yq = '0; m1_ov = 1'b0;

      vecs[0] = '{8'h00, 8'h01, 8'h00, 8'h01, 2'b00, 8'h00, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 8'h00, 8'h01, 2'b01, 8'h01, 1'b1};
      vecs[2] = '{8'h00, 8'h01, 8'h00, 8'h01, 2'b10, 8'h00, 1'b0};
      vecs[3] = '{8'h00, 8'h01, 8'h00, 8'h01, 2'b11, 8'h01, 1'b1};
      vecs[4] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b00, 8'hA5, 1'b1};
      vecs[5] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b01, 8'h3C, 1'b0};
      vecs[6] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b10, 8'hF0, 1'b0};
      vecs[7] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b11, 8'h0F, 1'b1};

      $display("[TB] reset with in_valid high");
      rst_n = 1'b0;
      applyStimulus(8'h5A, 8'hFF, 8'h11, 8'h22, 2'b01, 1'b1);
      tick();
      tick();
      checkOutput("rst_y_q8", b_y_q, 8'h00);
      checkOutput("rst_ov8", {7'b0, b_out_valid}, 8'h00);
      checkOutput("rst_y_q1", {7'b0, a_y_q}, 8'h00);
      checkOutput("rst_ov1", {7'b0, a_out_valid}, 8'h00);

      $display("[TB] combinational vector table");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(vecs[k].l0, vecs[k].l1, vecs[k].l2, vecs[k].l3, vecs[k].sel, 1'b0);
         #2;
         checkOutput($sformatf("tbl%0d_y8", k), b_y, vecs[k].exp8);
         checkOutput($sformatf("tbl%0d_y1", k), {7'b0, a_y}, {7'b0, vecs[k].exp1});
         #8;
      end

      $display("[TB] reset release then first valid beat");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'h00, 8'h01, 8'h00, 8'h00, 2'b01, 1'b1);
      tick();
      checkOutput("rel_y_q1", {7'b0, a_y_q}, 8'h01);
      checkOutput("rel_ov1", {7'b0, a_out_valid}, 8'h01);
      checkRegs("rel");

      $display("[TB] back-to-back select cycling");
      cyc = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'(k), 1'b1);
         tick();
         checkOutput($sformatf("cyc%0d_y_q8", k), b_y_q, cyc[k]);
         checkOutput($sformatf("cyc%0d_ov8", k), {7'b0, b_out_valid}, 8'h01);
      end

      $display("[TB] hold while in_valid low");
      applyStimulus(8'hA5, 8'h3C, 8'hF0, 8'h0F, 2'b01, 1'b1);
      tick();
      checkOutput("cap_y_q8", b_y_q, 8'h3C);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b0);
         #1;
         checkOutput($sformatf("hold%0d_y8", k), b_y, refSel(b_i0, b_i1, b_i2, b_i3, b_s));
         tick();
         checkOutput($sformatf("hold%0d_y_q8", k), b_y_q, 8'h3C);
         checkOutput($sformatf("hold%0d_ov8", k), {7'b0, b_out_valid}, 8'h00);
      end

      $display("[TB] reset mid-stream");
      applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 2'b00, 1'b1);
      tick();
      applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 2'b01, 1'b1);
      tick();
      checkOutput("pre_y_q8", b_y_q, 8'h22);
      rst_n = 1'b0;
      applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 2'b10, 1'b1);
      tick();
      checkOutput("mid_y_q8", b_y_q, 8'h00);
      checkOutput("mid_ov8", {7'b0, b_out_valid}, 8'h00);
      rst_n = 1'b1;
      applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, 2'b11, 1'b1);
      tick();
      checkOutput("resume_y_q8", b_y_q, 8'h44);
      checkOutput("resume_ov8", {7'b0, b_out_valid}, 8'h01);

      $display("[TB] unknown select");
      applyStimulus(8'h6B, 8'h00, 8'hFF, 8'h81, 2'bxx, 1'b0);
      #1;
      checkOutput("xsel_y8", b_y, refSel(b_i0, b_i1, b_i2, b_i3, b_s));
      checkOutput("xsel_y1", {7'b0, a_y}, refSel({7'b0, a_i0}, {7'b0, a_i1}, {7'b0, a_i2}, {7'b0, a_i3}, a_s));
      tick();

      $display("[TB] randomized traffic");
      for (int k = 0; k < 300; k++) begin
         rst_n = ($urandom_range(0, 15) != 0);
         applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                       2'($urandom), 1'($urandom_range(0, 3) != 0));
         #1;
         checkOutput("rnd_y8", b_y, refSel(b_i0, b_i1, b_i2, b_i3, b_s));
         checkOutput("rnd_y1", {7'b0, a_y}, refSel({7'b0, a_i0}, {7'b0, a_i1}, {7'b0, a_i2}, {7'b0, a_i3}, a_s));
         tick();
         checkRegs("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
